// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive bit decoder.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    LS_J   = 2'b00,
    LS_K   = 2'b01,
    LS_SE0 = 2'b10,
    LS_SE1 = 2'b11
  } line_state_t;

  localparam int USB_MAX_ONES      = 6;
  localparam int USB_BITS_PER_BYTE = 8;

  function automatic line_state_t decode_line(input logic dp, input logic dm);
    line_state_t ls;
    case ({dp, dm})
      2'b10:   ls = LS_J;
      2'b01:   ls = LS_K;
      2'b00:   ls = LS_SE0;
      default: ls = LS_SE1;
    endcase
    return ls;
  endfunction

endpackage

// File: rtl/usb_rx_bit_timer.sv
// D+ edge detector and resynchronizing bit-phase counter; pulses 'sample'
// once per bit time at SAMPLE_PHASE clocks after the most recent line edge.
module usb_rx_bit_timer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PHASE = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  input  logic d_plus,
  output logic sample
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic          dp_q;
  logic          line_edge;
  logic          locked;
  logic [CW-1:0] count;

  assign line_edge = d_plus ^ dp_q;

  // The counter stays parked until the first edge of a receive window, so an
  // idle J line is never sampled as a stream of ones before SYNC starts.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_q   <= 1'b1;
      count  <= '0;
      locked <= 1'b0;
    end else begin
      dp_q <= d_plus;
      if (!enable) begin
        count  <= '0;
        locked <= 1'b0;
      end else if (line_edge) begin
        count  <= CW'(1);
        locked <= 1'b1;
      end else if (locked) begin
        if (count == CW'(CLKS_PER_BIT - 1))
          count <= '0;
        else
          count <= count + CW'(1);
      end
    end
  end

  assign sample = enable && locked && (count == CW'(SAMPLE_PHASE));

endmodule

// File: rtl/usb_rx_bit_decoder.sv
// USB FS receive front end: bit timing, NRZI decode, bit unstuffing, byte count.
// Optional macro USB_RX_STUFF_ERR_EN enables the stuff-violation strobe.
module usb_rx_bit_decoder
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PHASE = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  input  logic d_plus_sync,
  input  logic d_minus_sync,
  output logic shift_enable,
  output logic serial_in,
  output logic byte_done,
  output logic eop,
  output logic stuff_err
);

  logic        sample;
  line_state_t line_state;
  logic        last_dp;
  logic        decoded;
  logic        stuff_bit;
  logic [2:0]  ones_cnt;
  logic [2:0]  bit_cnt;
  logic        shift_q;
  logic        eop_q;
  logic        byte_wrap;
  logic        byte_done_q;

  usb_rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SAMPLE_PHASE(SAMPLE_PHASE)
  ) u_timer (
    .clk    (clk),
    .n_rst  (n_rst),
    .enable (enable),
    .d_plus (d_plus_sync),
    .sample (sample)
  );

  assign line_state = decode_line(d_plus_sync, d_minus_sync);
  assign decoded    = (d_plus_sync == last_dp);
  assign stuff_bit  = (ones_cnt == 3'(USB_MAX_ONES));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      last_dp     <= 1'b1;
      ones_cnt    <= '0;
      bit_cnt     <= '0;
      shift_q     <= 1'b0;
      serial_in   <= 1'b1;
      eop_q       <= 1'b0;
      byte_wrap   <= 1'b0;
      byte_done_q <= 1'b0;
    end else begin
      shift_q     <= 1'b0;
      eop_q       <= 1'b0;
      byte_wrap   <= 1'b0;
      byte_done_q <= 1'b0;
      if (!enable) begin
        last_dp  <= 1'b1;
        ones_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        byte_done_q <= byte_wrap;
        if (sample) begin
          if (line_state == LS_SE0) begin
            eop_q    <= 1'b1;
            ones_cnt <= '0;
            bit_cnt  <= '0;
          end else begin
            // SE1 carries D+ high, so it decodes exactly like J here.
            last_dp <= d_plus_sync;
            if (stuff_bit) begin
              ones_cnt <= '0;
            end else begin
              shift_q   <= 1'b1;
              serial_in <= decoded;
              ones_cnt  <= decoded ? ones_cnt + 3'd1 : 3'd0;
              bit_cnt   <= bit_cnt + 3'd1;
              byte_wrap <= (bit_cnt == 3'(USB_BITS_PER_BYTE - 1));
            end
          end
        end
      end
    end
  end

  // Gating on enable keeps a strobe already in flight from leaking out once
  // the RX FSM has closed the receive window.
  assign shift_enable = shift_q & enable;
  assign eop          = eop_q & enable;
  assign byte_done    = byte_done_q & enable;

`ifdef USB_RX_STUFF_ERR_EN
  logic stuff_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      stuff_q <= 1'b0;
    else
      stuff_q <= enable && sample && (line_state != LS_SE0) && stuff_bit && decoded;
  end

  assign stuff_err = stuff_q & enable;
`else
  assign stuff_err = 1'b0;
`endif

endmodule

// File: doc/usb_rx_bit_decoder.md
# usb_rx_bit_decoder

Front end of the USB full-speed receive path: takes the synchronized D+/D- line pair, recovers bit timing, performs NRZI decoding and bit-unstuffing, and drives the serial-to-parallel shift register that assembles received bytes. It produces the `shift_enable`/`serial_in` pair that register consumes, plus byte-complete, end-of-packet and stuff-error strobes for the RX control FSM.

## Interface
- `CLKS_PER_BIT`, 8, system clocks per USB bit time (96 MHz / 12 Mbps); minimum 4.
- `SAMPLE_PHASE`, 3, timer count at which the line is sampled; must be < `CLKS_PER_BIT`.
- `clk` input 1 system clock, rising edge.
- `n_rst` input 1 asynchronous active-low reset.
- `enable` input 1 receive window open, from the RX FSM.
- `d_plus_sync` input 1 synchronized D+.
- `d_minus_sync` input 1 synchronized D-.
- `shift_enable` output 1 one-cycle pulse; shift `serial_in` into the byte register.
- `serial_in` output 1 decoded data bit; held between pulses.
- `byte_done` output 1 one-cycle pulse after the 8th data bit of a byte.
- `eop` output 1 one-cycle pulse on SE0 sample.
- `stuff_err` output 1 one-cycle pulse on bit-stuff violation (see Configuration).

## Operation
- Reset values: `shift_enable`, `byte_done`, `eop`, `stuff_err` = 0; `serial_in` = 1; timer, ones count, bit count = 0; last sampled D+ = 1 (idle J).
- Edge detect: D+ registered once; `edge` = current ^ registered.
- Bit timer: with `enable` low, held at 0. With `enable` high, counts 0..`CLKS_PER_BIT`-1 and wraps; on `edge` it reloads to 1 (the edge cycle is phase 0). `sample` strobe when count == `SAMPLE_PHASE`.
- Line state at `sample`: J (1,0), K (0,1), SE0 (0,0), SE1 (1,1, treated as J).
- SE0 at sample: `eop` pulse; no shift; ones count and bit count cleared; last D+ unchanged.
- Otherwise NRZI: decoded bit = 1 if D+ equals last sampled D+, else 0; last D+ updated.
- Unstuff: if ones count == 6, bit is a stuff bit: no shift, ones count -> 0; if decoded == 1, stuff violation. Else shift: `shift_enable` pulse, `serial_in` = decoded, ones count = decoded ? count+1 : 0, bit count +1.
- Bit count wraps 7->0; the wrap raises `byte_done`.
- `enable` falling mid-byte: timer, ones count, bit count cleared, last D+ = 1, no strobes in that or later cycles; partial byte discarded (RX FSM's responsibility).
- Stuff bit and SE0 never produce `shift_enable`. At most one of `shift_enable`/`eop`/`stuff_err` per bit time.

## Timing
- `shift_enable`, `serial_in`, `eop`, `stuff_err` registered: asserted the cycle after the `sample` cycle.
- `byte_done` asserted one cycle after the 8th `shift_enable`, i.e. when the shift register output holds the full byte.
- First sample of a packet: `SAMPLE_PHASE` cycles after the first SYNC edge; steady state, one sample per `CLKS_PER_BIT` cycles, re-aligned on every edge.
- Reset asserted at any time forces reset values asynchronously; first `sample` possible `SAMPLE_PHASE`+1 cycles after release with `enable` high.

## Configuration
- `USB_RX_STUFF_ERR_EN` defined: seventh consecutive 1 pulses `stuff_err` (bit still dropped, ones count -> 0).
- Undefined: `stuff_err` tied 0; bit after six 1s dropped regardless of value; no violation logic synthesized.

## Structure
- Package `usb_rx_pkg`: line-state enum (`LS_J`, `LS_K`, `LS_SE0`, `LS_SE1`), `USB_MAX_ONES` = 6, `USB_BITS_PER_BYTE` = 8.
- Sub-module `usb_rx_bit_timer`: edge detector plus resynchronizing phase counter, outputs `sample`. NRZI, unstuff and byte counting stay in the top.

## Test plan
- Reset with `enable` high, lines idle J -> all strobes 0, `serial_in` = 1; after release no `shift_enable` until first K.
- SYNC KJKJKJKK at 8 clk/bit -> 8 `shift_enable` pulses, bits 0,0,0,0,0,0,0,1, `byte_done` one cycle after the 8th, each pulse `SAMPLE_PHASE`+1 cycles after the bit's edge.
- Byte 0xFF (six 1s then stuffed 0) -> six 1 shifts, stuffed bit produces no pulse, next data bit shifts normally; `stuff_err` stays 0.
- Seven consecutive 1s with `USB_RX_STUFF_ERR_EN` -> `stuff_err` pulse on 7th, no shift; without macro -> no pulse, no shift.
- Two SE0 bit times then J -> `eop` pulse on each SE0 sample, no `shift_enable`, bit count cleared (next byte needs 8 fresh shifts for `byte_done`).
- `enable` dropped after 3 bits, raised again -> no strobes while low; next packet needs full 8 bits for `byte_done`; edges offset by ±1 clk resync the timer without missed or extra samples.
